mux_stim_seq: RTL and testbench
===============================

Name: mux_stim_seq

Overview:
- Upstream stimulus sequencer and response checker for the 2:1 mux exercise stage.
- Walks all 8 combinations of (S, I0, I1) into the mux and holds each for a programmable dwell.
- Samples the mux's 9-bit response vector and counts mismatches against an ideal 2:1 mux model.
- Sits between board controls (start/step buttons, already debounced) and the mux; results drive LEDs.

Parameters:
- DWELL_CYCLES, 4, cycles each vector is held before the response is sampled (legal range >= 1).
- CNT_W, 8, width of the error counter.
- CHK_MASK, 9'h103, response bits that are compared; a 1 enables the compare for that bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- step_mode  input  1  level; 1 = wait for step after each vector, 0 = free-run.
- step  input  1  one-cycle pulse; advances from HOLD.
- resp  input  9  response vector from the mux stage.
- S  output  1  select driven to the mux; equals vec_idx[2].
- I0  output  1  data 0 driven to the mux; equals vec_idx[1].
- I1  output  1  data 1 driven to the mux; equals vec_idx[0].
- vec_idx  output  3  current vector index, encoded as {S, I0, I1}.
- busy  output  1  high in DRIVE and HOLD.
- done  output  1  high in DONE.
- err_cnt  output  CNT_W  mismatches seen in the current run; saturates.
- last_fail_idx  output  3  vec_idx of the most recent mismatch.
- fail_seen  output  1  sticky; at least one mismatch in this run.

Behaviour:
- Reset: every output and all internal registers go to 0 and the FSM enters IDLE. Reset is asynchronous and applies mid-run.
- All outputs are registered. S, I0 and I1 are wired directly from vec_idx.
- Expected response, derived from vec_idx:
  - exp[0] = I0
  - exp[1] = I1
  - exp[8] = S ? I1 : I0
  - all other bits are don't-care unless CHK_MASK sets them; masked-in bits beyond 0, 1 and 8 expect 0.
- Mismatch = |((resp ^ exp) & CHK_MASK).
- IDLE:
  - start -> DRIVE; on the same edge, vec_idx=0, dwell counter=0, err_cnt=0, fail_seen=0, last_fail_idx=0.
- DRIVE:
  - The dwell counter increments each cycle.
  - The state lasts exactly DWELL_CYCLES cycles.
  - On the edge that ends the last DRIVE cycle, resp is compared. On a mismatch: err_cnt += 1 (saturating at all-ones), last_fail_idx = vec_idx, fail_seen = 1.
  - Same edge, next state:
    - if vec_idx == 7 -> DONE, with vec_idx holding 7;
    - else if step_mode = 1 -> HOLD, with vec_idx unchanged;
    - else -> DRIVE, with vec_idx + 1 and the counter cleared.
- HOLD:
  - Stimulus stays stable.
  - step -> DRIVE with vec_idx + 1 and the counter cleared.
  - If step_mode drops to 0 while in HOLD, advance on the next edge as if step had been pulsed.
- DONE:
  - Results hold and stimulus holds at the last vector.
  - start -> restart exactly as from IDLE.
- start while busy is ignored. step outside HOLD is ignored. If start and step arrive together, the state decides which is used (IDLE/DONE uses start, HOLD uses step).
- Free-run timing: with start accepted at edge 0, busy is high for cycles 1 .. 8*DWELL_CYCLES and done is high from cycle 8*DWELL_CYCLES+1.
- Index wrap: vec_idx never wraps inside a run; it returns to 0 only on restart.

Optional Feature:
- MUX_STIM_HALT_ON_FAIL_EN defined: the first mismatch sends the FSM to DONE on the compare edge. vec_idx and stimulus freeze at the failing vector, and err_cnt = 1.
- Undefined: the run always completes all 8 vectors. No port changes either way.

Decomposition:
- Package mux_stim_pkg holds:
  - state enum: IDLE, DRIVE, HOLD, DONE;
  - VEC_W = 3, RESP_W = 9;
  - response bit indices RESP_I0 = 0, RESP_I1 = 1, RESP_Y = 8;
  - default check mask 9'h103.
- One sub-module: mux_stim_checker. It is the combinational expected-value/mismatch compute plus the saturating err_cnt, last_fail_idx and fail_seen registers, enabled by a compare strobe from the FSM.

Test Plan:
- Ideal mux model on resp, DWELL_CYCLES=4, step_mode=0, start pulse -> vec_idx 0..7 each held 4 cycles; done at cycle 33; err_cnt=0, fail_seen=0.
- Faulty model with resp[8]=I1 always -> mismatches at idx 1 and 2; err_cnt=2, last_fail_idx=2, fail_seen=1.
- step_mode=1, ideal model -> FSM sits in HOLD after idx 0; each step pulse advances by one; 7 pulses reach DONE; step pulses during DRIVE are ignored.
- rst asserted mid-run at idx 5 -> all outputs 0 immediately (asynchronous); IDLE; new start runs from idx 0 with err_cnt cleared.
- CNT_W=2, model that always mismatches -> err_cnt saturates at 3 after the 3rd vector and stays 3 through DONE.
- MUX_STIM_HALT_ON_FAIL_EN defined, faulty model above -> DONE after idx 1; err_cnt=1, vec_idx=1, S/I0/I1=0/0/1 held.

Source files
------------

// File: rtl/mux_stim_pkg.sv
// mux_stim_pkg: shared types, widths and the ideal 2:1 mux response model.
`default_nettype none

package mux_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int VEC_W   = 3;
  localparam int RESP_W  = 9;
  localparam int RESP_I0 = 0;
  localparam int RESP_I1 = 1;
  localparam int RESP_Y  = 8;

  localparam logic [RESP_W-1:0] CHK_MASK_DEFAULT = 9'h103;

  // vec is {S, I0, I1}; bits not modelled here expect 0
  function automatic logic [RESP_W-1:0] exp_resp(input logic [VEC_W-1:0] vec);
    logic [RESP_W-1:0] e;
    e          = '0;
    e[RESP_I0] = vec[1];
    e[RESP_I1] = vec[0];
    e[RESP_Y]  = vec[2] ? vec[0] : vec[1];
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_stim_checker.sv
// mux_stim_checker: masked response compare with saturating error count,
// last failing index and sticky fail flag.
`default_nettype none

module mux_stim_checker
  import mux_stim_pkg::*;
#(
  parameter int                CNT_W    = 8,
  parameter logic [RESP_W-1:0] CHK_MASK = CHK_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cmp_en,
  input  logic [VEC_W-1:0]  vec_idx,
  input  logic [RESP_W-1:0] resp,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [VEC_W-1:0]  last_fail_idx,
  output logic              fail_seen
);

  assign mismatch = |((resp ^ exp_resp(vec_idx)) & CHK_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt       <= '0;
      last_fail_idx <= '0;
      fail_seen     <= 1'b0;
    end else if (clear) begin
      err_cnt       <= '0;
      last_fail_idx <= '0;
      fail_seen     <= 1'b0;
    end else if (cmp_en && mismatch) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      last_fail_idx <= vec_idx;
      fail_seen     <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_stim_seq.sv
// mux_stim_seq: walks all 8 (S, I0, I1) vectors with a programmable dwell and
// checks the mux response. Define MUX_STIM_HALT_ON_FAIL_EN to stop at the first mismatch.
`default_nettype none

module mux_stim_seq
  import mux_stim_pkg::*;
#(
  parameter int                DWELL_CYCLES = 4,
  parameter int                CNT_W        = 8,
  parameter logic [RESP_W-1:0] CHK_MASK     = CHK_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [RESP_W-1:0] resp,
  output logic              S,
  output logic              I0,
  output logic              I1,
  output logic [VEC_W-1:0]  vec_idx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [VEC_W-1:0]  last_fail_idx,
  output logic              fail_seen
);

`ifdef MUX_STIM_HALT_ON_FAIL_EN
  localparam bit HALT_ON_FAIL = 1'b1;
`else
  localparam bit HALT_ON_FAIL = 1'b0;
`endif

  localparam int             CW       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(DWELL_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = '1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [VEC_W-1:0] vec_nxt;
  logic             clear;
  logic             cmp_en;
  logic             mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vec_idx <= vec_nxt;
      busy    <= (state_nxt == DRIVE) || (state_nxt == HOLD);
      done    <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec_idx;
    clear     = 1'b0;
    cmp_en    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          vec_nxt   = '0;
          clear     = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == LAST_CNT) begin
          cmp_en = 1'b1;
          if ((vec_idx == LAST_VEC) || (HALT_ON_FAIL && mismatch)) begin
            state_nxt = DONE;
          end else if (step_mode) begin
            state_nxt = HOLD;
          end else begin
            cnt_nxt = '0;
            vec_nxt = vec_idx + VEC_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        // Dropping step_mode releases a held vector just like a step pulse
        if (step || !step_mode) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          vec_nxt   = vec_idx + VEC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign S  = vec_idx[2];
  assign I0 = vec_idx[1];
  assign I1 = vec_idx[0];

  mux_stim_checker #(
    .CNT_W    (CNT_W),
    .CHK_MASK (CHK_MASK)
  ) u_checker (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .cmp_en        (cmp_en),
    .vec_idx       (vec_idx),
    .resp          (resp),
    .mismatch      (mismatch),
    .err_cnt       (err_cnt),
    .last_fail_idx (last_fail_idx),
    .fail_seen     (fail_seen)
  );

endmodule

`default_nettype wire

// File: tb/tb_mux_stim_seq.sv
// tb_mux_stim_seq: directed checks of mux_stim_seq (default widths) plus a
// CNT_W=2 instance fed an always-wrong response for counter saturation.
`default_nettype none

module tb_mux_stim_seq;

`ifdef MUX_STIM_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, step_mode, step;
  logic [8:0] resp, resp2;
  logic       S, I0, I1, busy, done, fail_seen;
  logic [2:0] vec_idx, last_fail_idx;
  logic [7:0] err_cnt;
  logic       S2, I02, I12, busy2, done2, fail_seen2;
  logic [2:0] vec_idx2, last_fail_idx2;
  logic [1:0] err_cnt2;
  int         mode;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // mode 0: ideal mux; mode 1: output stuck to I1. Bits 7:2 carry junk that the mask must ignore.
  always_comb begin
    resp  = {((mode == 1) ? I1 : (S ? I1 : I0)), 6'b101101, I1, I0};
    resp2 = ~{(S2 ? I12 : I02), 6'b000000, I12, I02};
  end

  mux_stim_seq #(.DWELL_CYCLES(4), .CNT_W(8), .CHK_MASK(9'h103)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .resp(resp), .S(S), .I0(I0), .I1(I1), .vec_idx(vec_idx), .busy(busy),
    .done(done), .err_cnt(err_cnt), .last_fail_idx(last_fail_idx),
    .fail_seen(fail_seen)
  );

  mux_stim_seq #(.DWELL_CYCLES(4), .CNT_W(2), .CHK_MASK(9'h103)) dut2 (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .resp(resp2), .S(S2), .I0(I02), .I1(I12), .vec_idx(vec_idx2), .busy(busy2),
    .done(done2), .err_cnt(err_cnt2), .last_fail_idx(last_fail_idx2),
    .fail_seen(fail_seen2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_vec", 32'(vec_idx), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_results", 32'({err_cnt, last_fail_idx, fail_seen}), 32'd0);
    chk("rst_sel", 32'({S, I0, I1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy_done", 32'({busy, done}), 32'd0);

    // Free run, ideal response: vector (c-1)/4 during cycle c
    pulse_start();
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("run_vec_c%0d", c), 32'({busy, done, vec_idx}), 32'({2'b10, 3'((c - 1) / 4)}));
      chk($sformatf("run_sel_c%0d", c), 32'({S, I0, I1}), 32'((c - 1) / 4));
      if (c == 9)  chk("sat_cnt_after2", 32'(err_cnt2), HALT ? 32'd1 : 32'd2);
      if (c == 13) chk("sat_cnt_after3", 32'(err_cnt2), HALT ? 32'd1 : 32'd3);
      @(negedge clk);
    end
    chk("run_done_c33", 32'({busy, done, vec_idx}), 32'b01_111);
    chk("run_clean", 32'({err_cnt, fail_seen}), 32'd0);
    chk("sat_final", 32'({done2, err_cnt2, fail_seen2}), HALT ? 32'b1_01_1 : 32'b1_11_1);
    chk("sat_last_idx", 32'(last_fail_idx2), HALT ? 32'd0 : 32'd7);

    // Restart from DONE with output stuck at I1: fails on vectors 1 and 2
    mode = 1;
    pulse_start();
    chk("restart_clear", 32'({vec_idx, busy, err_cnt2, fail_seen2}), 32'b000_1_00_0);
    repeat (32) @(negedge clk);
    chk("fault_done", 32'(done), 32'd1);
    chk("fault_err_cnt", 32'(err_cnt), HALT ? 32'd1 : 32'd2);
    chk("fault_last_idx", 32'(last_fail_idx), HALT ? 32'd1 : 32'd2);
    chk("fault_seen", 32'(fail_seen), 32'd1);
    chk("fault_stim_hold", 32'({S, I0, I1}), HALT ? 32'b001 : 32'b111);

    // Step mode, ideal response
    mode = 0;
    step_mode = 1'b1;
    pulse_start();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_idx0", 32'({busy, done, vec_idx}), 32'b10_000);
    for (int k = 1; k <= 7; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk($sformatf("step_adv_%0d", k), 32'(vec_idx), 32'(k));
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      chk($sformatf("step_ign_%0d", k), 32'(vec_idx), 32'(k));
      repeat (3) @(negedge clk);
      chk($sformatf("step_hold_%0d", k), 32'({busy, done, vec_idx}), (k == 7) ? 32'b01_111 : 32'({2'b10, 3'(k)}));
    end
    chk("step_clean", 32'({err_cnt, fail_seen}), 32'd0);

    // Asynchronous reset while vector 5 is on the mux
    step_mode = 1'b0;
    mode = 1;
    pulse_start();
    repeat (21) @(negedge clk);
    chk("pre_rst_idx", 32'(vec_idx), HALT ? 32'd1 : 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_dut", 32'({vec_idx, busy, done, err_cnt, last_fail_idx, fail_seen}), 32'd0);
    chk("arst_sel", 32'({S, I0, I1}), 32'd0);
    chk("arst_dut2", 32'({vec_idx2, busy2, done2, err_cnt2, fail_seen2}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    @(negedge clk);
    chk("post_rst_idle", 32'({busy, done}), 32'd0);
    pulse_start();
    chk("post_rst_run", 32'({busy, vec_idx, err_cnt}), 32'({1'b1, 3'd0, 8'd0}));
    repeat (32) @(negedge clk);
    chk("post_rst_done", 32'({done, vec_idx, err_cnt, fail_seen}), 32'({1'b1, 3'd7, 8'd0, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
